// File: rtl/dispatch_scheduler_pkg.sv
// Shared opcode encodings, bus widths, queue entry layout and classification helpers
// used by the dispatch scheduler and the Dispatch stage.
package dispatch_scheduler_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int ADDR_W = 32;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP   = 6'd0;
  localparam op_t OP_LUI   = 6'd1;
  localparam op_t OP_AUIPC = 6'd2;
  localparam op_t OP_JAL   = 6'd3;
  localparam op_t OP_JALR  = 6'd4;
  localparam op_t OP_BEQ   = 6'd5;
  localparam op_t OP_BNE   = 6'd6;
  localparam op_t OP_BLT   = 6'd7;
  localparam op_t OP_BGE   = 6'd8;
  localparam op_t OP_BLTU  = 6'd9;
  localparam op_t OP_BGEU  = 6'd10;
  localparam op_t OP_LB    = 6'd11;
  localparam op_t OP_LH    = 6'd12;
  localparam op_t OP_LW    = 6'd13;
  localparam op_t OP_LBU   = 6'd14;
  localparam op_t OP_LHU   = 6'd15;
  localparam op_t OP_SB    = 6'd16;
  localparam op_t OP_SH    = 6'd17;
  localparam op_t OP_SW    = 6'd18;
  localparam op_t OP_ADDI  = 6'd19;
  localparam op_t OP_ORI   = 6'd24;
  localparam op_t OP_ADD   = 6'd28;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] a;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] pc;
    logic              is_mem;
    logic              wr_reg;
  } entry_t;

  function automatic logic is_mem_op(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic writes_rd(input op_t op);
    return !(op inside {OP_SB, OP_SH, OP_SW,
                        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU});
  endfunction

endpackage

// File: rtl/dispatch_scheduler_credit_counter.sv
// Free-entry credit counter for one downstream structure (ROB, RS or LSB).
// Latency: count updates on the next edge. Backpressure: nonzero gates the issuer; a release at full is dropped.
module credit_counter #(
  parameter int SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restore,
  input  logic inc,
  input  logic dec,
  output logic nonzero
);

  localparam int W = $clog2(SIZE + 1);
  localparam logic [W-1:0] FULL = W'(SIZE);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restore) begin
      cnt <= FULL;
    end else if (inc && !dec && cnt != FULL) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - W'(1);
    end
  end

  assign nonzero = (cnt != '0);

  release_at_full: assert property (@(posedge clk) disable iff (rst || restore)
                                    !(inc && !dec && cnt == FULL));

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order decoded-instruction queue issuing at most one op per cycle against ROB/RS/LSB credits.
// Latency: push into an empty queue shows on disp_s two cycles later. Backpressure: in_ready = queue not full.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int QDEPTH   = 4,
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSB_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              rob_release,
  input  logic              rs_release,
  input  logic              lsb_release,
  output logic              disp_s,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_a,
  output logic [REG_W-1:0]  disp_rd,
  output logic [ADDR_W-1:0] disp_pc,
  output logic              disp_to_lsb,
  output logic              disp_wr_reg
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] Q_FULL = (PW+1)'(QDEPTH);

  entry_t          q [QDEPTH];
  logic [PW-1:0]   head, tail;
  logic [PW:0]     count;
  entry_t          in_e, head_e, disp_q;
  logic            push, issue, active;
  logic            rob_nz, rs_nz, lsb_nz;

  // in_ready comes from registered occupancy only, so a same-cycle pop never frees a slot
  assign in_ready = (count < Q_FULL);
  assign active   = rdy && !flush;
  assign head_e   = q[head];
  assign push     = in_valid && in_ready && active;
  assign issue    = (count != '0) && rob_nz && (head_e.is_mem ? lsb_nz : rs_nz) && active;

  always_comb begin
    in_e        = '0;
    in_e.op     = in_op;
    in_e.a      = in_a;
    in_e.rd     = in_rd;
    in_e.pc     = in_pc;
    in_e.is_mem = is_mem_op(in_op);
    in_e.wr_reg = writes_rd(in_op);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (push)  tail <= tail + PW'(1);
      if (issue) head <= head + PW'(1);
      if (push && !issue)      count <= count + (PW+1)'(1);
      else if (issue && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_s <= 1'b0;
      disp_q <= '0;
    end else begin
      disp_s <= issue;
      disp_q <= issue ? head_e : '0;
    end
  end

  assign disp_op     = disp_q.op;
  assign disp_a      = disp_q.a;
  assign disp_rd     = disp_q.rd;
  assign disp_pc     = disp_q.pc;
  assign disp_to_lsb = disp_q.is_mem;
  assign disp_wr_reg = disp_q.wr_reg;

  credit_counter #(.SIZE(ROB_SIZE)) u_rob_cr (
    .clk     (clk),
    .rst     (rst),
    .restore (flush),
    .inc     (rob_release && active),
    .dec     (issue),
    .nonzero (rob_nz)
  );

  credit_counter #(.SIZE(RS_SIZE)) u_rs_cr (
    .clk     (clk),
    .rst     (rst),
    .restore (flush),
    .inc     (rs_release && active),
    .dec     (issue && !head_e.is_mem),
    .nonzero (rs_nz)
  );

  credit_counter #(.SIZE(LSB_SIZE)) u_lsb_cr (
    .clk     (clk),
    .rst     (rst),
    .restore (flush),
    .inc     (lsb_release && active),
    .dec     (issue && head_e.is_mem),
    .nonzero (lsb_nz)
  );

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Bench for dispatch_scheduler: directed scenarios plus randomized traffic against a queue/credit model.
module tb_dispatch_scheduler;
  import dispatch_scheduler_pkg::*;

  localparam int QD  = 4;
  localparam int ROB = 6;
  localparam int RS  = 4;
  localparam int LSB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rdy = 1'b1, flush = 1'b0, in_valid = 1'b0;
  logic [5:0]  in_op = '0;
  logic [31:0] in_a = '0, in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        rob_release = 1'b0, rs_release = 1'b0, lsb_release = 1'b0;
  logic        in_ready, disp_s, disp_to_lsb, disp_wr_reg;
  logic [5:0]  disp_op;
  logic [31:0] disp_a, disp_pc;
  logic [4:0]  disp_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dispatch_scheduler #(.QDEPTH(QD), .ROB_SIZE(ROB), .RS_SIZE(RS), .LSB_SIZE(LSB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_rd(in_rd), .in_pc(in_pc),
    .rob_release(rob_release), .rs_release(rs_release), .lsb_release(lsb_release),
    .disp_s(disp_s), .disp_op(disp_op), .disp_a(disp_a), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_to_lsb(disp_to_lsb), .disp_wr_reg(disp_wr_reg)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [4:0]  rd;
    logic [31:0] pc;
  } tb_ent_t;

  tb_ent_t     mq[$];
  int          m_rob = ROB, m_rs = RS, m_lsb = LSB;
  logic        e_s = 1'b0;
  tb_ent_t     e_ent = '{6'd0, 32'd0, 5'd0, 32'd0};

  function automatic bit tb_mem(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit tb_wr(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // One clock edge; the model consumes the inputs that were stable across it.
  task automatic tick();
    tb_ent_t e;
    bit      can_push, pop, mem;
    @(posedge clk);
    e_s   = 1'b0;
    e_ent = '{6'd0, 32'd0, 5'd0, 32'd0};
    if (rst || flush) begin
      mq.delete();
      m_rob = ROB; m_rs = RS; m_lsb = LSB;
    end else if (rdy) begin
      can_push = (mq.size() < QD);
      pop = 1'b0;
      mem = 1'b0;
      if (mq.size() > 0) begin
        mem = tb_mem(mq[0].op);
        pop = (m_rob > 0) && (mem ? (m_lsb > 0) : (m_rs > 0));
      end
      if (pop) begin
        e = mq.pop_front();
        e_s = 1'b1;
        e_ent = e;
        m_rob--;
        if (mem) m_lsb--; else m_rs--;
      end
      if (rob_release) m_rob = imin(m_rob + 1, ROB);
      if (rs_release)  m_rs  = imin(m_rs + 1, RS);
      if (lsb_release) m_lsb = imin(m_lsb + 1, LSB);
      if (in_valid && can_push) begin
        e = '{in_op, in_a, in_rd, in_pc};
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic push_op(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] a);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_rd = rd; in_a = a;
    tick();
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_rd = '0; in_a = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (disp_s !== 1'b0 || disp_op !== 6'd0 || disp_pc !== 32'd0 || disp_a !== 32'd0 ||
        disp_rd !== 5'd0 || disp_to_lsb !== 1'b0 || disp_wr_reg !== 1'b0) begin
      errors++;
      $display("FAIL reset_disp: disp_s=%b op=%0d pc=%h a=%h rd=%0d lsb=%b wr=%b, required all zero",
               disp_s, disp_op, disp_pc, disp_a, disp_rd, disp_to_lsb, disp_wr_reg);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic_issue();
    push_op(OP_ADDI, 32'h100, 5'd5, 32'h7);
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_early_issue: disp_s=%b required 0", disp_s);
    end
    tick();
    checks++;
    if (disp_s !== 1'b1 || disp_op !== OP_ADDI || disp_rd !== 5'd5 || disp_pc !== 32'h100 ||
        disp_a !== 32'h7 || disp_to_lsb !== 1'b0 || disp_wr_reg !== 1'b1) begin
      errors++;
      $display("FAIL basic_issue: s=%b op=%0d rd=%0d pc=%h a=%h lsb=%b wr=%b required 1/%0d/5/100/7/0/1",
               disp_s, disp_op, disp_rd, disp_pc, disp_a, disp_to_lsb, disp_wr_reg, OP_ADDI);
    end
    tick();
    checks++;
    if (disp_s !== 1'b0 || disp_pc !== 32'd0 || disp_op !== 6'd0) begin
      errors++;
      $display("FAIL basic_single_pulse: s=%b op=%0d pc=%h required 0/0/0", disp_s, disp_op, disp_pc);
    end
    do_flush();
  endtask

  task automatic test_lsb_credit();
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      push_op(OP_LW, 32'h200 + 32'(4 * i), 5'(i + 1), 32'h0);
      n += int'(disp_s);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n += int'(disp_s);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL lsb_stall_count: %0d issues required 2", n);
    end
    lsb_release = 1'b1;
    tick();
    lsb_release = 1'b0;
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL lsb_release_latency: disp_s=%b required 0", disp_s);
    end
    tick();
    checks++;
    if (disp_s !== 1'b1 || disp_pc !== 32'h208 || disp_to_lsb !== 1'b1 || disp_wr_reg !== 1'b1) begin
      errors++;
      $display("FAIL lsb_third_issue: s=%b pc=%h lsb=%b wr=%b required 1/208/1/1",
               disp_s, disp_pc, disp_to_lsb, disp_wr_reg);
    end
    do_flush();
  endtask

  task automatic test_in_order();
    push_op(OP_SW, 32'h300, 5'd0, 32'h10);
    push_op(OP_BEQ, 32'h304, 5'd0, 32'h20);
    checks++;
    if (disp_s !== 1'b1 || disp_op !== OP_SW || disp_pc !== 32'h300 ||
        disp_to_lsb !== 1'b1 || disp_wr_reg !== 1'b0) begin
      errors++;
      $display("FAIL order_sw: s=%b op=%0d pc=%h lsb=%b wr=%b required 1/%0d/300/1/0",
               disp_s, disp_op, disp_pc, disp_to_lsb, disp_wr_reg, OP_SW);
    end
    tick();
    checks++;
    if (disp_s !== 1'b1 || disp_op !== OP_BEQ || disp_pc !== 32'h304 ||
        disp_to_lsb !== 1'b0 || disp_wr_reg !== 1'b0) begin
      errors++;
      $display("FAIL order_beq: s=%b op=%0d pc=%h lsb=%b wr=%b required 1/%0d/304/0/0",
               disp_s, disp_op, disp_pc, disp_to_lsb, disp_wr_reg, OP_BEQ);
    end
    do_flush();
  endtask

  // Drains all credits: 2 loads + 4 ALU ops use every LSB, RS and ROB entry.
  task automatic drain_credits(output int n);
    logic [5:0] ops [6];
    ops = '{OP_LW, OP_LW, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    n = 0;
    for (int i = 0; i < 6; i++) begin
      push_op(ops[i], 32'h400 + 32'(4 * i), 5'd1, 32'h0);
      n += int'(disp_s);
    end
  endtask

  task automatic test_full_flush();
    int n;
    drain_credits(n);
    for (int i = 0; i < 4; i++) begin
      push_op(OP_ADDI, 32'h480 + 32'(4 * i), 5'd2, 32'h0);
      n += int'(disp_s);
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL full_issue_count: %0d issues required 6", n);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready: got %b required 0", in_ready);
    end
    push_op(OP_ORI, 32'h500, 5'd3, 32'h0);
    checks++;
    if (in_ready !== 1'b0 || disp_s !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: in_ready=%b disp_s=%b required 0/0", in_ready, disp_s);
    end
    do_flush();
    checks++;
    if (in_ready !== 1'b1 || disp_s !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: in_ready=%b disp_s=%b required 1/0", in_ready, disp_s);
    end
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n += int'(disp_s);
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL flush_empty: %0d issues after flush required 0", n);
    end
    push_op(OP_LW, 32'h510, 5'd4, 32'h0);
    push_op(OP_LW, 32'h514, 5'd4, 32'h0);
    n = int'(disp_s);
    tick();
    n += int'(disp_s);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL flush_credit_restore: %0d load issues required 2", n);
    end
    do_flush();
  endtask

  task automatic test_release_consume();
    int n;
    drain_credits(n);
    push_op(OP_ADDI, 32'h600, 5'd6, 32'h0);
    push_op(OP_ADDI, 32'h604, 5'd7, 32'h0);
    tick();
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL zero_credit_hold: disp_s=%b required 0", disp_s);
    end
    rob_release = 1'b1; rs_release = 1'b1;
    tick();
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL release_latency: disp_s=%b required 0", disp_s);
    end
    tick();
    rob_release = 1'b0; rs_release = 1'b0;
    checks++;
    if (disp_s !== 1'b1 || disp_pc !== 32'h600) begin
      errors++;
      $display("FAIL release_first: s=%b pc=%h required 1/600", disp_s, disp_pc);
    end
    tick();
    checks++;
    if (disp_s !== 1'b1 || disp_pc !== 32'h604) begin
      errors++;
      $display("FAIL release_consume_net: s=%b pc=%h required 1/604", disp_s, disp_pc);
    end
    tick();
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL no_stale_issue: disp_s=%b required 0", disp_s);
    end
    do_flush();
  endtask

  task automatic test_rdy_freeze();
    int n = 0;
    push_op(OP_ADDI, 32'h700, 5'd9, 32'h0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n += int'(disp_s);
    end
    rdy = 1'b1;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL rdy_freeze: %0d issues while frozen required 0", n);
    end
    tick();
    checks++;
    if (disp_s !== 1'b1 || disp_pc !== 32'h700) begin
      errors++;
      $display("FAIL rdy_resume: s=%b pc=%h required 1/700", disp_s, disp_pc);
    end
    tick();
    checks++;
    if (disp_s !== 1'b0) begin
      errors++;
      $display("FAIL rdy_single: disp_s=%b required 0", disp_s);
    end
    do_flush();
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    logic       x_lsb, x_wr;
    ops = '{OP_ADDI, OP_ORI, OP_ADD, OP_LW, OP_LB, OP_SW, OP_SH, OP_BEQ, OP_BNE, OP_JAL, OP_LUI, OP_LHU};
    for (int c = 0; c < 500; c++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      rdy         = ($urandom_range(0, 7) != 0);
      in_valid    = ($urandom_range(0, 9) < 6);
      in_op       = ops[$urandom_range(0, 11)];
      in_a        = $urandom;
      in_pc       = $urandom;
      in_rd       = 5'($urandom);
      rob_release = ($urandom_range(0, 2) == 0) && (m_rob < ROB);
      rs_release  = ($urandom_range(0, 2) == 0) && (m_rs < RS);
      lsb_release = ($urandom_range(0, 2) == 0) && (m_lsb < LSB);
      tick();
      x_lsb = e_s && tb_mem(e_ent.op);
      x_wr  = e_s && tb_wr(e_ent.op);
      checks++;
      if (disp_s !== e_s || disp_op !== e_ent.op || disp_a !== e_ent.a || disp_rd !== e_ent.rd ||
          disp_pc !== e_ent.pc || disp_to_lsb !== x_lsb || disp_wr_reg !== x_wr ||
          in_ready !== (mq.size() < QD)) begin
        errors++;
        $display("FAIL random_c%0d: got s=%b op=%0d pc=%h rd=%0d lsb=%b wr=%b rdy=%b required s=%b op=%0d pc=%h rd=%0d lsb=%b wr=%b rdy=%b",
                 c, disp_s, disp_op, disp_pc, disp_rd, disp_to_lsb, disp_wr_reg, in_ready,
                 e_s, e_ent.op, e_ent.pc, e_ent.rd, x_lsb, x_wr, (mq.size() < QD));
      end
    end
    rst = 1'b0; flush = 1'b0; rdy = 1'b1; in_valid = 1'b0;
    rob_release = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_lsb_credit();
    test_in_order();
    test_full_flush();
    test_release_consume();
    test_rdy_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
